// File: rtl/tjmono_emu_pkg.sv
// tjmono_emu_pkg: shared widths, field offsets, FSM encoding and the
// hit-word packing helper for the TJ-Monopix column readout emulator.
// No ports (package).
package tjmono_emu_pkg;

  localparam int COL_W  = 6;
  localparam int ROW_W  = 9;
  localparam int TE_W   = 6;
  localparam int LE_W   = 6;
  localparam int WORD_W = COL_W + ROW_W + TE_W + LE_W;

  // Field LSB positions inside the serialized word {COL, ROW, TE, LE}.
  localparam int LE_LSB  = 0;
  localparam int TE_LSB  = LE_LSB + LE_W;
  localparam int ROW_LSB = TE_LSB + TE_W;
  localparam int COL_LSB = ROW_LSB + ROW_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Pack one hit into the word layout transmitted MSB first.
  function automatic logic [WORD_W-1:0] pack_hit(
    input logic [COL_W-1:0] col,
    input logic [ROW_W-1:0] row,
    input logic [TE_W-1:0]  te,
    input logic [LE_W-1:0]  le
  );
    return {col, row, te, le};
  endfunction

endpackage

// File: rtl/emu_hit_fifo.sv
// emu_hit_fifo: synchronous first-word-fall-through FIFO for pending hits.
// Ports: clk, rst_n (sync active-low), wr/din push, rd pop (head on dout),
// full/empty flags and count (registered, update the cycle after wr/rd).
// A write into a full FIFO is accepted only when a pop happens the same cycle.
module emu_hit_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_nx;
  logic              full_r;
  logic              empty_r;
  logic              wr_en;
  logic              rd_en;

  assign rd_en = rd && !empty_r;
  assign wr_en = wr && (!full_r || rd_en);

  // Next fill level from the accepted push/pop pair.
  always_comb begin
    count_nx = count_r;
    case ({wr_en, rd_en})
      2'b10:   count_nx = count_r + CW'(1);
      2'b01:   count_nx = count_r - CW'(1);
      default: count_nx = count_r;
    endcase
  end

  // Pointer, level and flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      count_r <= count_nx;
      full_r  <= (count_nx == CW'(DEPTH));
      empty_r <= (count_nx == CW'(0));
    end
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;

endmodule

// File: rtl/tjmono_readout_emu.sv
// tjmono_readout_emu: chip-side emulator of the TJ-Monopix column readout.
// Ports: CLK, RST_N (sync active-low); HIT_WR/HIT_COL/HIT_ROW/HIT_LE/HIT_TE
// push hits; FREEZE/READ from the receiver; TOKEN, OUT (serial, MSB first),
// BUSY, HIT_FULL, LOST_CNT and READ_IGN_CNT (saturating) back out.
// FREEZE rising snapshots the fill level; each READ with TOKEN serializes one
// word over the following WORD_W cycles.
module tjmono_readout_emu #(
  parameter int ADDR_W = 4,
  parameter int WORD_W = 27
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       HIT_WR,
  input  logic [5:0] HIT_COL,
  input  logic [8:0] HIT_ROW,
  input  logic [5:0] HIT_LE,
  input  logic [5:0] HIT_TE,
  input  logic       FREEZE,
  input  logic       READ,
  output logic       TOKEN,
  output logic       OUT,
  output logic       BUSY,
  output logic       HIT_FULL,
  output logic [7:0] LOST_CNT,
  output logic [7:0] READ_IGN_CNT
);

  import tjmono_emu_pkg::*;

  localparam int CW  = ADDR_W + 1;
  localparam int BCW = $clog2(WORD_W);

  state_t            state;
  state_t            state_nx;
  logic              freeze_q;
  logic [CW-1:0]     frozen_cnt;
  logic [CW-1:0]     frozen_nx;
  logic [WORD_W-1:0] shift_reg;
  logic [BCW-1:0]    bit_cnt;
  logic              token_r;
  logic              busy_r;
  logic              out_r;
  logic [7:0]        lost_r;
  logic [7:0]        ign_r;
  logic              accept;
  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  emu_hit_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .wr    (HIT_WR),
    .din   (WORD_W'(pack_hit(HIT_COL, HIT_ROW, HIT_TE, HIT_LE))),
    .rd    (accept),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // TOKEN already implies frozen hits are in the FIFO; the empty guard only
  // keeps a pop from ever running past the write pointer.
  assign accept = (state == IDLE) && READ && token_r && !fifo_empty;

  // Serializer next state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) state_nx = SHIFT;
        else        state_nx = IDLE;
      end
      SHIFT: begin
        if (bit_cnt == BCW'(0)) state_nx = IDLE;
        else                    state_nx = SHIFT;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frozen count: snapshot on FREEZE rise (excludes a same-cycle write),
  // count down per accepted word, clear while FREEZE is low.
  always_comb begin
    frozen_nx = frozen_cnt;
    if (!FREEZE)        frozen_nx = '0;
    else if (!freeze_q) frozen_nx = fifo_count;
    else if (accept)    frozen_nx = frozen_cnt - CW'(1);
    else                frozen_nx = frozen_cnt;
  end

  // FSM, freeze tracking and registered TOKEN/BUSY.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      freeze_q   <= 1'b0;
      frozen_cnt <= '0;
      token_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state      <= state_nx;
      freeze_q   <= FREEZE;
      frozen_cnt <= frozen_nx;
      token_r    <= FREEZE && (frozen_nx != CW'(0));
      busy_r     <= (state_nx == SHIFT);
    end
  end

  // Shift path: OUT is registered and already shows the MSB in the cycle
  // after the accept, so the next bit comes from shift_reg[WORD_W-2].
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      out_r     <= 1'b0;
    end else if (accept) begin
      shift_reg <= fifo_dout;
      bit_cnt   <= BCW'(WORD_W - 1);
      out_r     <= fifo_dout[WORD_W-1];
    end else if (state == SHIFT) begin
      if (bit_cnt == BCW'(0)) begin
        out_r <= 1'b0;
      end else begin
        shift_reg <= shift_reg << 1;
        bit_cnt   <= bit_cnt - BCW'(1);
        out_r     <= shift_reg[WORD_W-2];
      end
    end else begin
      out_r <= 1'b0;
    end
  end

  // Saturating drop and ignored-READ counters.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      lost_r <= 8'd0;
      ign_r  <= 8'd0;
    end else begin
      if (HIT_WR && fifo_full && !accept && (lost_r != 8'hFF))
        lost_r <= lost_r + 8'd1;
      if ((state == SHIFT) && READ && (ign_r != 8'hFF))
        ign_r <= ign_r + 8'd1;
    end
  end

  assign TOKEN        = token_r;
  assign OUT          = out_r;
  assign BUSY         = busy_r;
  assign HIT_FULL     = fifo_full;
  assign LOST_CNT     = lost_r;
  assign READ_IGN_CNT = ign_r;

endmodule

// File: tb/tb_tjmono_readout_emu.sv
// Directed testbench for tjmono_readout_emu: single word, freeze snapshot,
// overflow with simultaneous push/pop, READ while busy, reset mid-word and a
// random loopback through a bench-side deserializer.
module tb_tjmono_readout_emu;

  logic       CLK = 1'b0;
  logic       RST_N, HIT_WR, FREEZE, READ;
  logic [5:0] HIT_COL, HIT_LE, HIT_TE;
  logic [8:0] HIT_ROW;
  logic       TOKEN, OUT, BUSY, HIT_FULL;
  logic [7:0] LOST_CNT, READ_IGN_CNT;

  int errors = 0;
  int checks = 0;

  logic [26:0] hits [0:31];
  logic [26:0] w;
  logic [31:0] r;
  int          served;

  tjmono_readout_emu #(.ADDR_W(4), .WORD_W(27)) dut (
    .CLK(CLK), .RST_N(RST_N), .HIT_WR(HIT_WR), .HIT_COL(HIT_COL),
    .HIT_ROW(HIT_ROW), .HIT_LE(HIT_LE), .HIT_TE(HIT_TE), .FREEZE(FREEZE),
    .READ(READ), .TOKEN(TOKEN), .OUT(OUT), .BUSY(BUSY), .HIT_FULL(HIT_FULL),
    .LOST_CNT(LOST_CNT), .READ_IGN_CNT(READ_IGN_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [26:0] mk(input int i);
    return {6'(i), 9'(i * 37), 6'(i + 7), 6'(63 - i)};
  endfunction

  task automatic set_hit(input logic [26:0] hw);
    HIT_COL = hw[26:21];
    HIT_ROW = hw[20:12];
    HIT_TE  = hw[11:6];
    HIT_LE  = hw[5:0];
  endtask

  task automatic push(input logic [26:0] hw);
    set_hit(hw);
    HIT_WR = 1'b1;
    tick();
    HIT_WR = 1'b0;
  endtask

  // Accept one READ, then sample OUT for 27 cycles (MSB first).
  task automatic read_word(output logic [26:0] rw);
    READ = 1'b1;
    tick();
    READ   = 1'b0;
    HIT_WR = 1'b0;
    rw = '0;
    for (int i = 0; i < 27; i++) begin
      rw = {rw[25:0], OUT};
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0; HIT_WR = 1'b0; FREEZE = 1'b0; READ = 1'b0;
    HIT_COL = '0; HIT_ROW = '0; HIT_LE = '0; HIT_TE = '0;
    repeat (3) tick();
    check("rst_token", TOKEN, 0);
    check("rst_out", OUT, 0);
    check("rst_busy", BUSY, 0);
    check("rst_full", HIT_FULL, 0);
    check("rst_lost", LOST_CNT, 0);
    check("rst_ign", READ_IGN_CNT, 0);
    RST_N = 1'b1;
    tick();

    // Single hit COL=5 ROW=300 TE=20 LE=10.
    hits[0] = {6'd5, 9'd300, 6'd20, 6'd10};
    push(hits[0]);
    check("pre_freeze_token", TOKEN, 0);
    FREEZE = 1'b1;
    tick();
    check("token_rise", TOKEN, 1);
    READ = 1'b1;
    tick();
    READ = 1'b0;
    check("token_fall", TOKEN, 0);
    check("busy_first", BUSY, 1);
    w = '0;
    for (int i = 0; i < 27; i++) begin
      w = {w[25:0], OUT};
      tick();
    end
    check("word1", w, 27'h0B2C50A);
    check("word1_col", w[26:21], 6'b000101);
    check("word1_row", w[20:12], 9'b100101100);
    check("word1_te", w[11:6], 6'b010100);
    check("word1_le", w[5:0], 6'b001010);
    check("busy_done", BUSY, 0);
    FREEZE = 1'b0;
    tick();

    // Freeze snapshot: 3 before, 2 during FREEZE.
    for (int i = 1; i <= 5; i++) hits[i] = mk(i);
    for (int i = 1; i <= 3; i++) push(hits[i]);
    FREEZE = 1'b1;
    tick();
    push(hits[4]);
    push(hits[5]);
    served = 0;
    for (int k = 0; k < 8; k++) begin
      if (TOKEN && served < 5) begin
        read_word(w);
        check("snap_word", w, hits[1 + served]);
        served++;
      end
    end
    check("snap_served", served, 3);
    check("snap_token_low", TOKEN, 0);
    FREEZE = 1'b0;
    tick();
    FREEZE = 1'b1;
    tick();
    served = 0;
    for (int k = 0; k < 8; k++) begin
      if (TOKEN && served < 2) begin
        read_word(w);
        check("snap2_word", w, hits[4 + served]);
        served++;
      end
    end
    check("snap2_served", served, 2);
    FREEZE = 1'b0;
    tick();

    // Overflow: 20 pushes into 16 entries.
    for (int i = 0; i < 21; i++) hits[i] = mk(i + 10);
    for (int i = 0; i < 20; i++) push(hits[i]);
    check("ovf_full", HIT_FULL, 1);
    check("ovf_lost", LOST_CNT, 4);
    FREEZE = 1'b1;
    tick();
    check("ovf_token", TOKEN, 1);
    set_hit(hits[20]);
    HIT_WR = 1'b1;
    read_word(w);
    check("ovf_word0", w, hits[0]);
    check("ovf_popwr_lost", LOST_CNT, 4);
    check("ovf_popwr_full", HIT_FULL, 1);
    for (int k = 1; k < 16; k++) begin
      read_word(w);
      check("ovf_word", w, hits[k]);
    end
    check("ovf_token_low", TOKEN, 0);
    check("ovf_not_full", HIT_FULL, 0);
    FREEZE = 1'b0;
    tick();
    FREEZE = 1'b1;
    tick();
    read_word(w);
    check("ovf_late_word", w, hits[20]);
    FREEZE = 1'b0;
    tick();

    // READ while busy, then boundary of the next accept.
    for (int i = 0; i < 3; i++) hits[i] = mk(50 + i);
    for (int i = 0; i < 3; i++) push(hits[i]);
    FREEZE = 1'b1;
    tick();
    READ = 1'b1;
    tick();
    READ = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      READ = (c == 5 || c == 27);
      if (c == 6) check("ign_one", READ_IGN_CNT, 1);
      if (c == 27) check("busy_last_bit", BUSY, 1);
      tick();
    end
    READ = 1'b0;
    check("busy_gap", BUSY, 0);
    check("ign_two", READ_IGN_CNT, 2);
    READ = 1'b1;
    tick();
    READ = 1'b0;
    check("reaccept_busy", BUSY, 1);
    repeat (16) tick();
    check("bit10", OUT, hits[1][10]);

    // Reset mid-word.
    RST_N = 1'b0;
    tick();
    check("mid_rst_out", OUT, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_token", TOKEN, 0);
    check("mid_rst_full", HIT_FULL, 0);
    check("mid_rst_lost", LOST_CNT, 0);
    check("mid_rst_ign", READ_IGN_CNT, 0);
    RST_N = 1'b1;
    FREEZE = 1'b0;
    tick();
    FREEZE = 1'b1;
    tick();
    tick();
    check("mid_rst_fifo_empty", TOKEN, 0);
    FREEZE = 1'b0;
    tick();

    // Random loopback.
    for (int i = 0; i < 12; i++) begin
      r = $urandom();
      hits[i] = r[26:0];
      push(hits[i]);
    end
    FREEZE = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      read_word(w);
      check("loop_word", w, hits[i]);
    end
    check("loop_lost", LOST_CNT, 0);
    check("loop_token_low", TOKEN, 0);
    FREEZE = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
